// File: rtl/instruction_cache.sv
// Read-only, direct-mapped instruction cache: 8 blocks x 16 bytes over a 10-bit fetch address.
// A miss stalls the CPU, fetches the whole block from instruction memory, then replays the lookup.
module instruction_cache (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  pc,
    output logic [31:0]  instruction,
    output logic         busywait,
    output logic         mem_read,
    output logic [5:0]   mem_address,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait
);

    typedef enum logic [1:0] {IDLE, FETCH, FILL} state_t;

    state_t       state, state_nxt;
    logic [127:0] data_arr [8];
    logic [2:0]   tag_arr  [8];
    logic [7:0]   valid;
    logic [5:0]   miss_addr;

    logic [2:0]   pc_tag;
    logic [2:0]   pc_idx;
    logic [1:0]   pc_off;
    logic         hit;
    logic         fill_we;
    logic         unused_pc_bits;

    assign pc_tag         = pc[9:7];
    assign pc_idx         = pc[6:4];
    assign pc_off         = pc[3:2];
    assign unused_pc_bits = ^{pc[31:10], pc[1:0]};

    assign hit     = valid[pc_idx] && (tag_arr[pc_idx] == pc_tag);
    assign fill_we = (state == FETCH) && !mem_busywait;

    // Word select reads only the array, so returned memory data reaches instruction one cycle later.
    always_comb begin
        instruction = 32'h0;
        case (pc_off)
            2'd0:    instruction = data_arr[pc_idx][31:0];
            2'd1:    instruction = data_arr[pc_idx][63:32];
            2'd2:    instruction = data_arr[pc_idx][95:64];
            default: instruction = data_arr[pc_idx][127:96];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            valid     <= 8'h00;
            miss_addr <= 6'h00;
        end else begin
            state <= state_nxt;
            if (state == IDLE && !hit)
                miss_addr <= pc[9:4];
            if (fill_we)
                valid[miss_addr[2:0]] <= 1'b1;
        end
    end

    // Data and tags carry no reset; the valid bits alone decide whether they mean anything.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_arr[miss_addr[2:0]] <= mem_readdata;
            tag_arr[miss_addr[2:0]]  <= miss_addr[5:3];
        end
    end

    always_comb begin
        state_nxt   = state;
        busywait    = 1'b0;
        mem_read    = 1'b0;
        mem_address = 6'h00;
        case (state)
            IDLE: begin
                if (!hit) begin
                    busywait  = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                busywait    = 1'b1;
                mem_read    = 1'b1;
                mem_address = miss_addr;
                if (!mem_busywait)
                    state_nxt = FILL;
            end
            FILL: begin
                busywait  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (reset)
            busywait = 1'b0;
    end

endmodule

// File: tb/tb_instruction_cache.sv
// Bench for instruction_cache: directed scenarios plus random fetches against a tag/valid
// reference model and a variable-latency block memory.
module tb_instruction_cache;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  pc = 32'h0;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    int checks = 0;
    int errors = 0;

    logic [127:0] mem_blocks [64];
    int           mem_lat = 1;
    int           mcnt;

    // Reference model: which block each line holds, nothing about how the DUT sequences.
    bit   [7:0]   mv;
    logic [2:0]   mt [8];

    instruction_cache dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .instruction  (instruction),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    always #5 clk = ~clk;

    // Memory answers in the mem_lat-th cycle of a request.
    always @(posedge clk or posedge reset) begin
        if (reset)
            mcnt <= 0;
        else if (!mem_read || !mem_busywait)
            mcnt <= 0;
        else
            mcnt <= mcnt + 1;
    end
    assign mem_busywait = !(mem_read && (mcnt >= mem_lat - 1));
    assign mem_readdata = mem_blocks[mem_address];

    function automatic logic [31:0] word_of(input logic [9:0] a);
        logic [127:0] b;
        b = mem_blocks[a[9:4]];
        return b[a[3:2]*32 +: 32];
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic [9:0] a, input int lat);
        int   cyc;
        int   nrd;
        bit   hit;
        logic [31:0] r;
        r = $urandom();
        r[9:0] = a;
        pc = r;
        mem_lat = lat;
        #1;
        hit = mv[a[6:4]] && (mt[a[6:4]] == a[9:7]);
        cyc = 0;
        nrd = 0;
        while (busywait === 1'b1 && cyc < 200) begin
            if (mem_read === 1'b1) begin
                nrd++;
                chk("mem_address", mem_address, a[9:4]);
            end
            step;
            cyc++;
        end
        chk("busy_cycles", cyc, hit ? 0 : lat + 2);
        chk("mem_read_cycles", nrd, hit ? 0 : lat);
        chk("instruction", instruction, word_of(a));
        chk("mem_read_idle", mem_read, 1'b0);
        mv[a[6:4]] = 1'b1;
        mt[a[6:4]] = a[9:7];
    endtask

    task automatic hold;
        step;
        chk("hold_busywait", busywait, 1'b0);
        chk("hold_mem_read", mem_read, 1'b0);
    endtask

    task automatic reset_pulse;
        reset = 1'b1;
        #1;
        chk("rst_busywait", busywait, 1'b0);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_address", mem_address, 6'h00);
        mv = '0;
        step;
        chk("rst_hold_busywait", busywait, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        int        cyc;
        logic [5:0] q [$];
        logic [9:0] a;

        for (int i = 0; i < 64; i++)
            mem_blocks[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        mem_blocks[0] = 128'h0000000C_0000000B_0000000A_00000009;
        mv = '0;

        // Power-on reset
        repeat (2) step;
        chk("por_busywait", busywait, 1'b0);
        chk("por_mem_read", mem_read, 1'b0);
        chk("por_mem_address", mem_address, 6'h00);
        reset = 1'b0;

        // Cold miss then hits in the same block
        access(10'h000, 5);
        chk("cold_word", instruction, 32'h00000009);
        hold;
        access(10'h004, 5);
        chk("hit_word1", instruction, 32'h0000000A);
        hold;
        access(10'h008, 5);
        chk("hit_word2", instruction, 32'h0000000B);
        hold;
        access(10'h00C, 5);
        chk("hit_word3", instruction, 32'h0000000C);
        hold;

        // Conflict on index 0, then the original block misses again
        access(10'h080, 3);
        hold;
        access(10'h000, 2);
        hold;

        // Independent indices
        access(10'h010, 4);
        access(10'h070, 1);
        access(10'h014, 4);
        access(10'h07C, 4);
        access(10'h008, 4);
        chk("block0_kept", instruction, 32'h0000000B);

        // Reset in the third fetch cycle
        pc = 32'h020;
        mem_lat = 6;
        #1;
        step;
        step;
        step;
        chk("pre_rst_mem_read", mem_read, 1'b1);
        reset_pulse;
        access(10'h020, 3);
        hold;
        access(10'h000, 2);

        // PC moves away while a fetch is in flight
        pc = 32'h030;
        mem_lat = 4;
        #1;
        step;
        pc = 32'h040;
        #1;
        cyc = 1;
        q.delete();
        while (busywait === 1'b1 && cyc < 200) begin
            if (mem_read === 1'b1)
                q.push_back(mem_address);
            step;
            cyc++;
        end
        chk("glitch_cycles", cyc, 12);
        chk("glitch_reads", q.size(), 8);
        for (int i = 0; i < q.size() && i < 8; i++)
            chk("glitch_addr", q[i], (i < 4) ? 6'h03 : 6'h04);
        chk("glitch_word", instruction, word_of(10'h040));
        mv[3] = 1'b1; mt[3] = 3'd0;
        mv[4] = 1'b1; mt[4] = 3'd0;
        access(10'h030, 3);
        hold;

        // Random fetches over two tags so hits and conflicts both occur
        for (int n = 0; n < 40; n++) begin
            a = {1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            access(a, $urandom_range(1, 6));
            if ($urandom_range(0, 9) == 0)
                reset_pulse;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_cache.md
INSTRUCTION_CACHE -- requirements
Module: instruction_cache

Interface
REQ-001 Parameters: none; geometry fixed at 8 blocks x 16 bytes, direct-mapped, 10-bit instruction address space.
REQ-002 CLK  input  1  single clock; all state changes on rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 PC  input  32  fetch address from CPU; bits [9:0] used, [31:10] ignored.
REQ-005 INSTRUCTION  output  32  fetched word; valid only while BUSYWAIT=0.
REQ-006 BUSYWAIT  output  1  1 = CPU shall stall and hold PC.
REQ-007 MEM_READ  output  1  block read request to instruction memory.
REQ-008 MEM_ADDRESS  output  6  block address (byte address [9:4]).
REQ-009 MEM_READDATA  input  128  returned block; word0 in [31:0], word3 in [127:96].
REQ-010 MEM_BUSYWAIT  input  1  memory busy; data valid in the cycle it is 0 while MEM_READ=1.

Function
REQ-011 Address split: tag=PC[9:7], index=PC[6:4], word offset=PC[3:2]; PC[1:0] ignored.
REQ-012 Storage: per block 128-bit data, 3-bit tag, 1 valid bit; no dirty bit (read-only).
REQ-013 Hit = valid[index] AND tag[index]==PC[9:7], evaluated combinationally in IDLE.
REQ-014 INSTRUCTION = data[index] word selected by offset, combinational from PC and array contents.
REQ-015 FSM states: IDLE, FETCH, FILL.
REQ-016 IDLE: hit -> BUSYWAIT=0, stay IDLE; miss -> BUSYWAIT=1 same cycle, latch PC[9:4] into miss register, next edge -> FETCH.
REQ-017 FETCH: BUSYWAIT=1, MEM_READ=1, MEM_ADDRESS=miss register; held stable until memory responds.
REQ-018 FETCH: on edge with MEM_BUSYWAIT=0, write MEM_READDATA into block miss[2:0], tag<=miss[5:3], valid<=1, -> FILL.
REQ-019 FILL: MEM_READ=0, BUSYWAIT=1 for exactly one cycle; next edge -> IDLE, where the lookup now hits.
REQ-020 Miss penalty = memory latency + 2 cycles (miss-detect cycle + FILL) before BUSYWAIT falls.
REQ-021 MEM_READ and MEM_ADDRESS are 0 in IDLE and FILL.
REQ-022 PC change during FETCH/FILL does not alter the in-flight fetch; refill targets the latched address, then IDLE re-evaluates the current PC.
REQ-023 Conflict miss (same index, different tag) overwrites block unconditionally; no write-back.
REQ-024 MEM_BUSYWAIT is ignored outside FETCH.
REQ-025 Combinational paths PC->BUSYWAIT and PC->INSTRUCTION permitted; no combinational path MEM_READDATA->INSTRUCTION.

Reset
REQ-026 RESET=1 immediately forces state=IDLE, all valid bits=0, miss register=0, MEM_READ=0, MEM_ADDRESS=0.
REQ-027 While RESET=1, BUSYWAIT=0; data and tag arrays are not cleared.
REQ-028 RESET asserted mid-FETCH aborts the request (MEM_READ drops asynchronously); nothing written to arrays.
REQ-029 First PC after reset deassertion always misses.

Verification
REQ-030 Cold miss: reset, PC=0x000, memory 5-cycle latency, block=0x0000000C_0000000B_0000000A_00000009 -> BUSYWAIT=1 for 7 cycles, MEM_ADDRESS=0, then BUSYWAIT=0, INSTRUCTION=0x00000009.
REQ-031 Hits after fill: PC=0x004, 0x008, 0x00C -> BUSYWAIT=0 each cycle, INSTRUCTION=0x0A, 0x0B, 0x0C; MEM_READ never asserted.
REQ-032 Conflict: after REQ-030, PC=0x080 (tag 1, index 0) -> miss, MEM_ADDRESS=0x08; then PC=0x000 misses again.
REQ-033 Index independence: fill PC=0x010 and 0x070 -> both hit afterward; block 0 contents unchanged.
REQ-034 Reset mid-fetch: miss on PC=0x020, RESET pulse in 3rd FETCH cycle -> MEM_READ=0 at once, state IDLE, PC=0x020 misses again after reset.
REQ-035 PC glitch in FETCH: miss on 0x030, PC moved to 0x040 during FETCH -> MEM_ADDRESS stays 0x03, block 3 filled, then fresh miss for 0x040.
